// File: rtl/sseg_capture.sv
// rtl/sseg_capture.sv - recovers four hex nibbles from a multiplexed active-low seven-segment bus
module sseg_capture #(
    parameter int STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic        valid,
    output logic        err,
    output logic [3:0]  digit_err
);
    typedef enum logic {SETTLE, HELD} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CNT);

    state_t      state, state_next;
    logic [10:0] sync1, s, s_prev;
    logic [7:0]  cnt, cnt_next;
    logic        accept, qual;
    logic [3:0]  s_an;
    logic [6:0]  s_seg;
    logic [1:0]  k;
    logic [4:0]  dec;
    logic [15:0] shadow, shadow_next;
    logic [3:0]  shadow_err, shadow_err_next;
    logic [3:0]  seen, seen_next;

    assign s_an  = s[10:7];
    assign s_seg = s[6:0];

    // Returns {invalid, nibble}; anything outside the sixteen glyphs decodes as 0 with invalid set
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        case (p)
            7'b1000000: decode_seg = 5'h00;
            7'b1111001: decode_seg = 5'h01;
            7'b0100100: decode_seg = 5'h02;
            7'b0110000: decode_seg = 5'h03;
            7'b0011001: decode_seg = 5'h04;
            7'b0010010: decode_seg = 5'h05;
            7'b0000010: decode_seg = 5'h06;
            7'b1111000: decode_seg = 5'h07;
            7'b0000000: decode_seg = 5'h08;
            7'b0010000: decode_seg = 5'h09;
            7'b0001000: decode_seg = 5'h0A;
            7'b0000011: decode_seg = 5'h0B;
            7'b1000110: decode_seg = 5'h0C;
            7'b0100001: decode_seg = 5'h0D;
            7'b0000110: decode_seg = 5'h0E;
            7'b0001110: decode_seg = 5'h0F;
            default:    decode_seg = 5'h10;
        endcase
    endfunction

    // Synchronizer resets to all ones so an idle display never looks like a selected digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '1;
            s      <= '1;
            s_prev <= '1;
            state  <= SETTLE;
            cnt    <= '0;
        end else begin
            sync1  <= {an, seg};
            s      <= sync1;
            s_prev <= s;
            state  <= state_next;
            cnt    <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        if (s != s_prev) begin
            state_next = SETTLE;
            cnt_next   = 8'd1;
        end else begin
            if (cnt != 8'hFF)
                cnt_next = cnt + 8'd1;
            if (state == SETTLE && cnt == STABLE) begin
                accept     = 1'b1;
                state_next = HELD;
            end
        end
    end

    always_comb begin
        k = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!s_an[i])
                k = 2'(i);
    end

    assign qual = accept && $onehot(~s_an);
    assign dec  = decode_seg(s_seg);

    always_comb begin
        shadow_next     = shadow;
        shadow_err_next = shadow_err;
        seen_next       = seen;
        if (qual) begin
            shadow_next[{k, 2'b00} +: 4] = dec[3:0];
            shadow_err_next[k]           = dec[4];
            seen_next[k]                 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            shadow_err <= '0;
            seen       <= '0;
            digits     <= '0;
            digit_err  <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
        end else begin
            shadow     <= shadow_next;
            shadow_err <= shadow_err_next;
            valid      <= 1'b0;
            err        <= 1'b0;
            if (seen_next == 4'hF) begin
                digits    <= shadow_next;
                digit_err <= shadow_err_next;
                valid     <= 1'b1;
                err       <= |shadow_err_next;
                seen      <= '0;
            end else begin
                seen <= seen_next;
            end
        end
    end
endmodule

// File: tb/tb_sseg_capture.sv
// tb/tb_sseg_capture.sv - scoreboard bench for sseg_capture
module tb_sseg_capture;
    localparam int STABLE_CNT = 4;
    localparam int LATENCY    = 2 + STABLE_CNT + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] digits;
    logic        valid, err;
    logic [3:0]  digit_err;

    sseg_capture #(.STABLE_CNT(STABLE_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
        .digits(digits), .valid(valid), .err(err), .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  de;
        logic        e;
        int          c;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0, n_fail = 0, n_valid = 0, n_pushed = 0, cyc = 0;
    logic [6:0]  seg_tab [16];
    logic [3:0]  m_seen;
    logic [15:0] m_shadow, last_digits;
    logic [3:0]  m_serr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("digits", 32'(digits), 32'(e.d));
                check("digit_err", 32'(digit_err), 32'(e.de));
                check("err", 32'(err), 32'(e.e));
                check("latency", 32'(cyc - e.c), 32'(LATENCY));
            end
        end
        if (rst_n && !valid && err)
            check("stray_err", 32'd1, 32'd0);
    end

    task automatic model_clear();
        m_seen = '0; m_shadow = '0; m_serr = '0;
    endtask

    // Holds {an,seg} for 'hold' clocks and updates the reference model when it should be accepted
    task automatic drive(input logic [3:0] a, input logic [6:0] sg, input int hold);
        int          zeros, k;
        logic [3:0]  nib;
        logic        bad;
        exp_t        e;
        @(posedge clk);
        #1;
        an = a; seg = sg;
        zeros = 0; k = 0;
        for (int i = 0; i < 4; i++)
            if (!a[i]) begin zeros++; k = i; end
        if (hold >= LATENCY && zeros == 1) begin
            nib = 4'h0; bad = 1'b1;
            for (int i = 0; i < 16; i++)
                if (seg_tab[i] == sg) begin nib = 4'(i); bad = 1'b0; end
            m_shadow[k*4 +: 4] = nib;
            m_serr[k]          = bad;
            m_seen[k]          = 1'b1;
            if (m_seen == 4'hF) begin
                e.d = m_shadow; e.de = m_serr; e.e = |m_serr; e.c = cyc;
                sb.push_back(e);
                n_pushed++;
                last_digits = m_shadow;
                m_seen = '0;
            end
        end
        repeat (hold - 1) @(posedge clk);
    endtask

    task automatic frame(input logic [15:0] v);
        for (int d = 3; d >= 0; d--)
            drive(~(4'b1 << d), seg_tab[v[d*4 +: 4]], 10);
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_clear();
        last_digits = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_digit_err", 32'(digit_err), 32'h0);
        rst_n = 1'b1;

        drive(4'b0111, 7'b1111001, 10);
        drive(4'b1011, 7'b0100100, 10);
        drive(4'b1101, 7'b0110000, 10);
        drive(4'b1110, 7'b0011001, 10);

        frame(16'hABCD);
        frame(16'hEF08);

        // glitch on digit 1 must not count; a false accept would let digit 0 complete the frame early
        drive(4'b0111, seg_tab[5], 10);
        drive(4'b1011, seg_tab[6], 10);
        drive(4'b1101, seg_tab[7], 3);
        drive(4'b1011, seg_tab[6], 10);
        drive(4'b1110, seg_tab[9], 10);
        drive(4'b1101, seg_tab[7], 10);

        drive(4'b0111, seg_tab[1], 10);
        drive(4'b1011, seg_tab[2], 10);
        drive(4'b1101, 7'b1111110, 10);
        drive(4'b1110, seg_tab[3], 10);

        drive(4'b0111, seg_tab[4], 10);
        drive(4'b1011, seg_tab[4], 10);
        drive(4'b1111, seg_tab[8], 20);
        drive(4'b1100, seg_tab[8], 20);
        drive(4'b1101, seg_tab[2], 10);
        drive(4'b1110, seg_tab[1], 10);

        drive(4'b0111, seg_tab[12], 10);
        drive(4'b1011, seg_tab[13], 10);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b1101, seg_tab[14], 10);
        drive(4'b1110, seg_tab[15], 10);
        frame(16'h5A3C);

        repeat (20) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("valid_count", 32'(n_valid), 32'(n_pushed));
        check("hold_digits", 32'(digits), 32'(last_digits));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
